// File: rtl/aes_inv_top.sv
// aes_inv_top: iterative AES-128 decryption core with one inverse round per clock.
// Define AES_INV_KEY_CACHE_EN to cache k10 and skip key expansion on a repeated key.
package aes_inv_pkg;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xt(x);
    end
    return p;
  endfunction
  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 1; i < 11; i++) r = (i < int'(n)) ? xt(r) : r;
    return r;
  endfunction
  function automatic logic [127:0] inv_mix(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0] a0, a1, a2, a3;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = x[127-32*c -: 8];
      a1 = x[119-32*c -: 8];
      a2 = x[111-32*c -: 8];
      a3 = x[103-32*c -: 8];
      y[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      y[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      y[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      y[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return y;
  endfunction
endpackage

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  import aes_inv_pkg::*;
  logic [7:0] b;
  always_comb begin
    b = ginv(a_i);
    s_o = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  end
endmodule

module aes_inv_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  import aes_inv_pkg::*;
  logic [7:0] b;
  always_comb begin
    b = rotl(a_i, 1) ^ rotl(a_i, 3) ^ rotl(a_i, 6) ^ 8'h05;
    s_o = ginv(b);
  end
endmodule

module aes_inv_top (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         AES_inv_en,
  input  logic [127:0] AES_inv_data_in,
  input  logic [127:0] AES_inv_key_in,
  output logic [127:0] AES_inv_data_out,
  output logic         AES_inv_data_out_valid
);
  import aes_inv_pkg::*;
  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_e;
  state_e state_q, state_d;
  logic [127:0] st_q, st_d, rk_q, rk_d, out_q, out_d;
  logic [3:0] cnt_q, cnt_d;
  logic go_q, go_d, hit_q, hit_d, vld_q, vld_d;
  logic [127:0] isr, isb, ark, fwd, inv;
  logic [31:0] t, sw_in, sw_out, g, f0, f1, f2;
  logic [7:0] rc;
`ifdef AES_INV_KEY_CACHE_EN
  logic [127:0] cache_key_q, cache_key_d, cache_k10_q, cache_k10_d;
  logic cache_ok_q, cache_ok_d;
`endif
  always_comb begin
    isr = '0;
    for (int n = 0; n < 16; n++)
      isr[127-8*n -: 8] = st_q[127-8*(4*((n/4 - n%4) & 3) + n%4) -: 8];
  end
  for (genvar i = 0; i < 16; i++) begin : g_isb
    aes_inv_sbox u_isb (.a_i(isr[127-8*i -: 8]), .s_o(isb[127-8*i -: 8]));
  end
  // One SubWord serves both directions: RotWord(w3) forward, RotWord(w3^w2) backward
  for (genvar i = 0; i < 4; i++) begin : g_sb
    aes_sbox u_sb (.a_i(sw_in[8*i+7 -: 8]), .s_o(sw_out[8*i+7 -: 8]));
  end
  always_comb begin
    t = (state_q == ROUND) ? rk_q[31:0] ^ rk_q[63:32] : rk_q[31:0];
    sw_in = {t[23:0], t[31:24]};
    rc = rcon((state_q == ROUND) ? 4'(cnt_q + 4'd1) : cnt_q);
    g = sw_out ^ {rc, 24'h0};
    f0 = rk_q[127:96] ^ g;
    f1 = rk_q[95:64] ^ f0;
    f2 = rk_q[63:32] ^ f1;
    fwd = {f0, f1, f2, rk_q[31:0] ^ f2};
    inv = {rk_q[127:96] ^ g, rk_q[95:64] ^ rk_q[127:96], rk_q[63:32] ^ rk_q[95:64], t};
    ark = isb ^ inv;
  end
  always_comb begin
    state_d = state_q;
    st_d = st_q;
    rk_d = rk_q;
    cnt_d = cnt_q;
    go_d = go_q;
    hit_d = hit_q;
    out_d = out_q;
    vld_d = 1'b0;
`ifdef AES_INV_KEY_CACHE_EN
    cache_key_d = cache_key_q;
    cache_k10_d = cache_k10_q;
    cache_ok_d = cache_ok_q;
`endif
    case (state_q)
      IDLE: begin
        if (go_q) begin
          state_d = hit_q ? ROUND : KEYEXP;
          cnt_d = hit_q ? 4'd9 : 4'd1;
          go_d = 1'b0;
          hit_d = 1'b0;
        end else if (AES_inv_en) begin
          go_d = 1'b1;
          st_d = AES_inv_data_in;
          rk_d = AES_inv_key_in;
          cnt_d = 4'd1;
`ifdef AES_INV_KEY_CACHE_EN
          if (cache_ok_q && AES_inv_key_in == cache_key_q) begin
            rk_d = cache_k10_q;
            st_d = AES_inv_data_in ^ cache_k10_q;
            hit_d = 1'b1;
          end else begin
            cache_key_d = AES_inv_key_in;
            cache_ok_d = 1'b0;
          end
`endif
        end
      end
      KEYEXP: begin
        rk_d = fwd;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd10) begin
          st_d = st_q ^ fwd;
          state_d = ROUND;
          cnt_d = 4'd9;
`ifdef AES_INV_KEY_CACHE_EN
          cache_k10_d = fwd;
          cache_ok_d = 1'b1;
`endif
        end
      end
      ROUND: begin
        rk_d = inv;
        st_d = (cnt_q == 4'd0) ? ark : inv_mix(ark);
        cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        state_d = (cnt_q == 4'd0) ? DONE : ROUND;
      end
      DONE: begin
        out_d = st_q;
        vld_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge AES_clk) begin
    if (!AES_rst_n) begin
      state_q <= IDLE;
      st_q <= '0;
      rk_q <= '0;
      cnt_q <= '0;
      go_q <= 1'b0;
      hit_q <= 1'b0;
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q <= st_d;
      rk_q <= rk_d;
      cnt_q <= cnt_d;
      go_q <= go_d;
      hit_q <= hit_d;
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end
`ifdef AES_INV_KEY_CACHE_EN
  always_ff @(posedge AES_clk) begin
    if (!AES_rst_n) begin
      cache_key_q <= '0;
      cache_k10_q <= '0;
      cache_ok_q <= 1'b0;
    end else begin
      cache_key_q <= cache_key_d;
      cache_k10_q <= cache_k10_d;
      cache_ok_q <= cache_ok_d;
    end
  end
`endif
  assign AES_inv_data_out = out_q;
  assign AES_inv_data_out_valid = vld_q;
endmodule
